// File: rtl/pipe_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pipe_pkg
//  Purpose  : Shared types and encodings for the pipeline controller:
//             FSM state enum, next-PC source encodings, register index width.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package pipe_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_cmp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_cmp
//  Purpose  : Combinational load-use detector. Flags when the load in EX
//             writes a register (other than r0) read by the instruction in ID.
//  Ports    : ex_memread, ex_rt  - load in EX and its destination
//             id_rs, id_rt       - source registers of instruction in ID
//             load_use           - hazard detected this cycle
//  Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_cmp
  import pipe_pkg::*;
(
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             load_use
);

  // r0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign load_use = ex_memread
                  & (ex_rt != '0)
                  & ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl
//  Purpose  : Five-stage pipeline controller. Generates latch enables,
//             bubble flushes and next-PC select for load-use hazards,
//             taken branches/jumps and variable-latency data memory, with a
//             sticky timeout error when data memory never acknowledges.
//  Ports    : clk, rst                  - clock, async active-high reset
//             id_rs, id_rt              - ID source registers
//             ex_memread, ex_rt         - load in EX and its destination
//             mem_branch/zero/jump      - control-flow flags in MEM
//             mem_memread/memwrite      - data memory access in MEM
//             dmem_ack / dmem_req       - data memory handshake
//             *_en, *_flush             - latch enables / bubble inserts
//             pc_sel                    - next-PC source (PC_SEQ/BR/JMP)
//             mem_err                   - sticky timeout error
//  Revision : 1.0  initial release
// ============================================================================
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             mem_branch,
  input  logic             mem_zero,
  input  logic             mem_jump,
  input  logic             mem_memread,
  input  logic             mem_memwrite,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic [1:0]       pc_sel,
  output logic             mem_err
);

  localparam int             CNT_W       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  logic w_access;
  logic w_redirect;
  logic w_load_use;
  logic w_stall;

  pipe_hazard_cmp u_hazard (
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .load_use   (w_load_use)
  );

  assign w_access   = mem_memread | mem_memwrite;
  assign w_redirect = (mem_branch & mem_zero) | mem_jump;
  // Memory stall: an access started in RUN without ack, or any MEM_WAIT
  // cycle without ack. The ack cycle itself proceeds like a RUN cycle.
  assign w_stall    = ((r_state == MEM_WAIT) | w_access) & ~dmem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_access && !dmem_ack) begin
            r_state <= MEM_WAIT;
            r_cnt   <= CNT_W'(1);
          end
        end
        MEM_WAIT: begin
          // An ack in the same cycle the count hits the limit still wins.
          if (dmem_ack) begin
            r_state <= RUN;
            r_cnt   <= '0;
          end else if (r_cnt == TIMEOUT_VAL) begin
            r_state <= ERROR;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ERROR: begin
          r_state <= ERROR;
        end
        default: begin
          r_state <= RUN;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    dmem_req     = 1'b0;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    pc_sel       = PC_SEQ;

    if (rst) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}         = 5'b00000;
      {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}    = 4'b1111;
    end else begin
      case (r_state)
        RUN, MEM_WAIT: begin
          dmem_req = (r_state == MEM_WAIT) | w_access;
          if (w_stall) begin
            // Freeze everything; the bubble into MEM/WB keeps WB idle.
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
            mem_wb_flush = 1'b1;
          end else if (w_redirect) begin
            // Redirect squashes the younger instructions, which makes any
            // load-use stall on them irrelevant.
            pc_sel       = mem_jump ? PC_JMP : PC_BR;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
          end else if (w_load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        default: begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
        end
      endcase
    end
  end

  assign mem_err = (r_state == ERROR);

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_ctrl
//  Purpose  : Self-checking bench for pipe_ctrl (MEM_TIMEOUT = 4): table of
//             single-cycle RUN vectors plus hand-written multi-cycle
//             sequences for memory stalls, timeout and reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       ex_memread, mem_branch, mem_zero, mem_jump;
  logic       mem_memread, mem_memwrite, dmem_ack;
  logic       dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic [1:0] pc_sel;
  logic       mem_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_memread   (ex_memread),
    .ex_rt        (ex_rt),
    .mem_branch   (mem_branch),
    .mem_zero     (mem_zero),
    .mem_jump     (mem_jump),
    .mem_memread  (mem_memread),
    .mem_memwrite (mem_memwrite),
    .dmem_ack     (dmem_ack),
    .dmem_req     (dmem_req),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .id_ex_en     (id_ex_en),
    .ex_mem_en    (ex_mem_en),
    .mem_wb_en    (mem_wb_en),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_flush (ex_mem_flush),
    .mem_wb_flush (mem_wb_flush),
    .pc_sel       (pc_sel),
    .mem_err      (mem_err)
  );

  // Output word: {dmem_req, pc_sel, flushes(if_id,id_ex,ex_mem,mem_wb),
  //               enables(pc,if_id,id_ex,ex_mem,mem_wb)}
  localparam logic [11:0] O_NORM  = {1'b0, 2'd0, 4'b0000, 5'b11111};
  localparam logic [11:0] O_NREQ  = {1'b1, 2'd0, 4'b0000, 5'b11111};
  localparam logic [11:0] O_STALL = {1'b1, 2'd0, 4'b0001, 5'b00000};
  localparam logic [11:0] O_RST   = {1'b0, 2'd0, 4'b1111, 5'b00000};
  localparam logic [11:0] O_ERR   = 12'h000;
  localparam logic [11:0] O_LU    = {1'b0, 2'd0, 4'b0100, 5'b00111};
  localparam logic [11:0] O_LUREQ = {1'b1, 2'd0, 4'b0100, 5'b00111};
  localparam logic [11:0] O_BR    = {1'b0, 2'd1, 4'b1110, 5'b11111};
  localparam logic [11:0] O_BRREQ = {1'b1, 2'd1, 4'b1110, 5'b11111};
  localparam logic [11:0] O_JMP   = {1'b0, 2'd2, 4'b1110, 5'b11111};
  localparam logic [11:0] O_JMPRQ = {1'b1, 2'd2, 4'b1110, 5'b11111};

  typedef struct {
    string       name;
    logic        exr;
    logic [4:0]  ert, rs, rt;
    logic        br, zr, jmp, rd, wr, ack;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [13];

  function automatic logic [11:0] outs();
    return {dmem_req, pc_sel, if_id_flush, id_ex_flush, ex_mem_flush,
            mem_wb_flush, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
  endfunction

  task automatic check(input string name, input logic [11:0] exp,
                       input logic exp_err);
    logic [11:0] act;
    act = outs();
    n_cmp++;
    if (act !== exp || mem_err !== exp_err) begin
      n_bad++;
      $display("FAIL %s: outputs=%b mem_err=%b, required outputs=%b mem_err=%b",
               name, act, mem_err, exp, exp_err);
    end
  endtask

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0; ex_memread = 1'b0;
    mem_branch = 1'b0; mem_zero = 1'b0; mem_jump = 1'b0;
    mem_memread = 1'b0; mem_memwrite = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    ex_memread = v.exr; ex_rt = v.ert; id_rs = v.rs; id_rt = v.rt;
    mem_branch = v.br; mem_zero = v.zr; mem_jump = v.jmp;
    mem_memread = v.rd; mem_memwrite = v.wr; dmem_ack = v.ack;
  endtask

  initial begin
    //            name           exr ert   rs    rt    br   zr   jmp  rd   wr   ack  exp
    vecs[0]  = '{"idle",        0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, O_NORM};
    vecs[1]  = '{"lu_rs",       1, 5'd5, 5'd5, 5'd9, 0, 0, 0, 0, 0, 0, O_LU};
    vecs[2]  = '{"lu_rt",       1, 5'd7, 5'd3, 5'd7, 0, 0, 0, 0, 0, 0, O_LU};
    vecs[3]  = '{"lu_r0",       1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, O_NORM};
    vecs[4]  = '{"no_load",     0, 5'd5, 5'd5, 5'd5, 0, 0, 0, 0, 0, 0, O_NORM};
    vecs[5]  = '{"lu_nomatch",  1, 5'd5, 5'd4, 5'd6, 0, 0, 0, 0, 0, 0, O_NORM};
    vecs[6]  = '{"br_taken",    0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0, 0, O_BR};
    vecs[7]  = '{"br_not_tkn",  0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, 0, O_NORM};
    vecs[8]  = '{"jump",        0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0, O_JMP};
    vecs[9]  = '{"jump_br",     0, 5'd0, 5'd0, 5'd0, 1, 1, 1, 0, 0, 0, O_JMP};
    vecs[10] = '{"lu_plus_br",  1, 5'd5, 5'd5, 5'd0, 1, 1, 0, 0, 0, 0, O_BR};
    vecs[11] = '{"rd_ack",      0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 1, O_NREQ};
    vecs[12] = '{"wr_ack_jmp",  0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1, 1, O_JMPRQ};

    // ---- reset state, including reset overriding active hazards ----
    rst = 1'b1;
    clear_inputs();
    #3 check("reset_idle", O_RST, 1'b0);
    mem_branch = 1'b1; mem_zero = 1'b1; ex_memread = 1'b1; ex_rt = 5'd5;
    id_rs = 5'd5; mem_memread = 1'b1;
    #1 check("reset_busy", O_RST, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    #1 check("post_reset", O_NORM, 1'b0);

    // ---- single-cycle RUN vectors ----
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1 check(vecs[i].name, vecs[i].exp, 1'b0);
    end

    // ---- read acked after 3 stall cycles ----
    @(negedge clk);
    clear_inputs();
    mem_memread = 1'b1;
    #1 check("rd3_stall0", O_STALL, 1'b0);
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      #1 check($sformatf("rd3_stall%0d", i), O_STALL, 1'b0);
    end
    @(negedge clk);
    dmem_ack = 1'b1;
    #1 check("rd3_ack", O_NREQ, 1'b0);
    @(negedge clk);
    clear_inputs();
    #1 check("rd3_run", O_NORM, 1'b0);

    // ---- ack cycle leaving MEM_WAIT still honours load-use ----
    @(negedge clk);
    mem_memwrite = 1'b1;
    #1 check("wr_stall", O_STALL, 1'b0);
    @(negedge clk);
    dmem_ack = 1'b1; ex_memread = 1'b1; ex_rt = 5'd12; id_rt = 5'd12;
    #1 check("wr_ack_lu", O_LUREQ, 1'b0);
    @(negedge clk);
    clear_inputs();
    #1 check("wr_run", O_NORM, 1'b0);

    // ---- ack arriving as the counter hits the limit (branch taken too) ----
    @(negedge clk);
    mem_memread = 1'b1;
    #1 check("lim_stall0", O_STALL, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      #1 check($sformatf("lim_wait%0d", i), O_STALL, 1'b0);
    end
    @(negedge clk);
    dmem_ack = 1'b1; mem_branch = 1'b1; mem_zero = 1'b1;
    #1 check("lim_ack_br", O_BRREQ, 1'b0);
    @(negedge clk);
    clear_inputs();
    #1 check("lim_run", O_NORM, 1'b0);

    // ---- reset pulse mid MEM_WAIT, released before the next clock edge ----
    @(negedge clk);
    mem_memread = 1'b1;
    #1 check("rw_stall0", O_STALL, 1'b0);
    @(negedge clk);
    mem_memread = 1'b0;
    #1 check("rw_wait", O_STALL, 1'b0);
    #1 rst = 1'b1;
    #1 check("rw_rst", O_RST, 1'b0);
    rst = 1'b0;
    #1 check("rw_release", O_NORM, 1'b0);
    @(negedge clk);
    #1 check("rw_run", O_NORM, 1'b0);

    // ---- timeout: 4 wait cycles without ack, then sticky ERROR ----
    @(negedge clk);
    mem_memread = 1'b1;
    #1 check("to_stall0", O_STALL, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      #1 check($sformatf("to_wait%0d", i), O_STALL, 1'b0);
    end
    @(negedge clk);
    #1 check("to_error", O_ERR, 1'b1);
    @(negedge clk);
    dmem_ack = 1'b1; mem_jump = 1'b1;
    #1 check("err_ack", O_ERR, 1'b1);
    @(negedge clk);
    clear_inputs();
    #1 check("err_idle", O_ERR, 1'b1);
    @(negedge clk);
    #1 check("err_sticky", O_ERR, 1'b1);
    #1 rst = 1'b1;
    #1 check("err_rst", O_RST, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("err_release", O_NORM, 1'b0);
    @(negedge clk);
    #1 check("err_run", O_NORM, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, 16, max dmem wait cycles before error (range 1..255).
REQ-002 Reset rst, asynchronous, active-high; clock clk.
REQ-003 clk  input  1  pipeline clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 id_rs, id_rt  input  5 each  source registers of instruction in ID.
REQ-006 ex_memread  input  1  instruction in EX is a load; ex_rt  input  5  its destination.
REQ-007 mem_branch, mem_zero, mem_jump  input  1 each  branch/condition/jump flags of instruction in MEM.
REQ-008 mem_memread, mem_memwrite  input  1 each  instruction in MEM accesses data memory.
REQ-009 dmem_ack  input  1  data memory completes current access this cycle.
REQ-010 dmem_req  output  1  data memory request, held until ack.
REQ-011 pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  output  1 each  latch/PC load enables.
REQ-012 if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  output  1 each  load bubble (all-zero controls) into latch.
REQ-013 pc_sel  output  2  next-PC source: 0 sequential, 1 branch target, 2 jump target.
REQ-014 mem_err  output  1  sticky timeout error.

Function
REQ-015 FSM states RUN, MEM_WAIT, ERROR; outputs combinational from state and inputs.
REQ-016 RUN default: all enables 1, all flushes 0, pc_sel 0, dmem_req 0.
REQ-017 access = mem_memread | mem_memwrite; in RUN with access, dmem_req = 1.
REQ-018 RUN, access, dmem_ack=1: no stall, zero added latency.
REQ-019 RUN, access, dmem_ack=0: all enables 0 this cycle, mem_wb_flush 1, next state MEM_WAIT, wait counter := 1.
REQ-020 MEM_WAIT: dmem_req 1, all enables 0, mem_wb_flush 1; counter increments each cycle without ack.
REQ-021 MEM_WAIT with dmem_ack=1: behave as RUN cycle (REQ-016, REQ-022, REQ-023 apply), mem_wb_flush 0, next state RUN, counter := 0.
REQ-022 Redirect when (mem_branch & mem_zero) or mem_jump, in RUN or MEM_WAIT ack cycle: pc_sel 1 (branch) or 2 (jump; jump wins if both), if_id_flush, id_ex_flush, ex_mem_flush = 1.
REQ-023 Load-use: ex_memread & ex_rt != 0 & (ex_rt == id_rs | ex_rt == id_rt) -> pc_en 0, if_id_en 0, id_ex_flush 1 for that cycle; suppressed when redirect active.
REQ-024 Counter reaching MEM_TIMEOUT without ack -> ERROR.
REQ-025 ERROR: all enables 0, all flushes 0, dmem_req 0, mem_err 1; exits only on reset.
REQ-026 Counter width ceil(log2(MEM_TIMEOUT+1)) bits; never wraps.
REQ-027 ack arriving in the same cycle counter hits MEM_TIMEOUT counts as success (RUN).

Reset
REQ-028 rst asserted: state RUN, counter 0, mem_err 0, immediately regardless of clk.
REQ-029 While rst high: all enables 0, all flushes 1, pc_sel 0, dmem_req 0.
REQ-030 rst during MEM_WAIT or ERROR abandons the access; first cycle after release is RUN.

Structure
REQ-031 Package pipe_pkg holds state enum and pc_sel encodings PC_SEQ=0, PC_BR=1, PC_JMP=2.
REQ-032 Load-use comparison in sub-module pipe_hazard_cmp (combinational).

Verification
REQ-033 ex_memread=1, ex_rt=5, id_rs=5 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1; ex_rt=0 -> no stall.
REQ-034 mem_branch=1, mem_zero=1 -> pc_sel=1, three flushes 1 one cycle; mem_jump=1 -> pc_sel=2.
REQ-035 mem_memread=1, ack after 3 cycles -> 3 stall cycles with mem_wb_flush=1, then RUN, enables 1.
REQ-036 MEM_TIMEOUT=4, no ack -> ERROR after 4 wait cycles, mem_err=1 sticky until rst.
REQ-037 Load-use plus branch same cycle -> redirect only, pc_en=1, pc_sel=1.
REQ-038 rst pulse mid-MEM_WAIT -> outputs per REQ-029 at once, RUN after release, mem_err=0.
